// File: rtl/spi_ram_pkg.sv
// Shared opcode and FSM state types for the SPI-attached RAM controller.
package spi_ram_pkg;

  localparam int unsigned DataW = 8;
  localparam int unsigned CmdW  = 10;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic {
    IDLE    = 1'b0,
    TX_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/spi_dpram.sv
// Byte-wide RAM: one write port and one registered read port.
// Neither the array nor the read register is reset.
module spi_dpram
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_SIZE-1:0] waddr_i,
  input  logic [DataW-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_SIZE-1:0] raddr_i,
  output logic [DataW-1:0]     rdata_o
);

  logic [DataW-1:0] mem_q [MEM_DEPTH];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    // Read register only moves on a read, so the last value is held in between.
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder between an SPI slave and a byte RAM: edge-detects rx_valid,
// tracks auto-incrementing write/read addresses and holds read data for the slave.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CmdW-1:0]   rx_data,
  input  logic              rx_valid,
  output logic [DataW-1:0]  tx_data,
  output logic              tx_valid,
  output logic              cmd_err
);

  logic                 rx_valid_q;
  logic                 accept;
  opcode_e              op;
  logic [DataW-1:0]     payload;

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_ok_q, wr_ok_d;
  logic                 rd_ok_q, rd_ok_d;
  state_e               state_q, state_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 tx_zero_q, tx_zero_d;
  logic                 mem_we, mem_re;
  logic [DataW-1:0]     mem_rdata;

  assign accept  = rx_valid & ~rx_valid_q;
  assign op      = opcode_e'(rx_data[9:8]);
  assign payload = rx_data[7:0];

  always_comb begin
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_ok_d   = wr_ok_q;
    rd_ok_d   = rd_ok_q;
    state_d   = state_q;
    cmd_err_d = 1'b0;
    tx_zero_d = tx_zero_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (accept) begin
      // Any accepted command leaves TX_HOLD unless it is itself a valid read.
      state_d = IDLE;
      unique case (op)
        WR_ADDR: begin
          wr_addr_d = payload[ADDR_SIZE-1:0];
          wr_ok_d   = 1'b1;
        end
        WR_DATA: begin
          if (wr_ok_q) begin
            mem_we    = 1'b1;
            wr_addr_d = wr_addr_q + 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        RD_ADDR: begin
          rd_addr_d = payload[ADDR_SIZE-1:0];
          rd_ok_d   = 1'b1;
        end
        RD_DATA: begin
          if (rd_ok_q) begin
            mem_re    = 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = TX_HOLD;
            tx_zero_d = 1'b0;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // rx_valid_q=1 so a level already high at release is not a new command.
      rx_valid_q <= 1'b1;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_ok_q    <= 1'b0;
      rd_ok_q    <= 1'b0;
      state_q    <= IDLE;
      cmd_err_q  <= 1'b0;
      tx_zero_q  <= 1'b1;
    end else begin
      rx_valid_q <= rx_valid;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_ok_q    <= wr_ok_d;
      rd_ok_q    <= rd_ok_d;
      state_q    <= state_d;
      cmd_err_q  <= cmd_err_d;
      tx_zero_q  <= tx_zero_d;
    end
  end

  spi_dpram #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we & ~rst),
    .waddr_i (wr_addr_q),
    .wdata_i (payload),
    .re_i    (mem_re & ~rst),
    .raddr_i (rd_addr_q),
    .rdata_o (mem_rdata)
  );

  // RAM read register has no reset; mask it to zero until the first real read.
  assign tx_data  = tx_zero_q ? '0 : mem_rdata;
  assign tx_valid = (state_q == TX_HOLD);
  assign cmd_err  = cmd_err_q;

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, the number of 8-bit memory words.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, the address width in bits (MEM_DEPTH = 2**ADDR_SIZE).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port rx_data, input, 10 bits: the command from the SPI slave; [9:8] is the opcode and [7:0] is the payload.
REQ-006 SHALL have port rx_valid, input, 1 bit: the command-valid level from the SPI slave; it may stay high for many cycles.
REQ-007 SHALL have port tx_data, output, 8 bits: the read data returned to the SPI slave.
REQ-008 SHALL have port tx_valid, output, 1 bit: tx_data is valid while this is high.
REQ-009 SHALL have port cmd_err, output, 1 bit: a one-cycle pulse when a command is rejected.

Function
REQ-010 SHALL accept a command only on a rising edge of rx_valid (rx_valid=1 while the registered rx_valid_q=0); later high cycles SHALL be ignored.
REQ-011 SHALL decode the opcode as follows: 00 = WR_ADDR, 01 = WR_DATA, 10 = RD_ADDR, 11 = RD_DATA.
REQ-012 On WR_ADDR, SHALL load wr_addr with payload[ADDR_SIZE-1:0] and set wr_addr_ok at the next edge.
REQ-013 On WR_DATA with wr_addr_ok=1, SHALL write payload to mem[wr_addr] at the next edge, then increment wr_addr modulo MEM_DEPTH.
REQ-014 On RD_ADDR, SHALL load rd_addr and set rd_addr_ok at the next edge.
REQ-015 On RD_DATA with rd_addr_ok=1, SHALL register tx_data = mem[rd_addr] and tx_valid=1 at the next edge, then increment rd_addr modulo MEM_DEPTH (255 wraps to 0).
REQ-016 SHALL have an accept-to-effect latency of exactly 1 clock for every command.
REQ-017 WR_DATA without wr_addr_ok, or RD_DATA without rd_addr_ok, SHALL cause no memory or address change and SHALL pulse cmd_err for 1 cycle.
REQ-018 The FSM SHALL have states IDLE (tx_valid=0) and TX_HOLD (tx_valid=1).
REQ-019 The FSM SHALL go IDLE->TX_HOLD on an accepted, valid RD_DATA.
REQ-020 The FSM SHALL stay in TX_HOLD until the next accepted command; that command SHALL go to IDLE, except a valid RD_DATA, which SHALL stay in TX_HOLD and reload tx_data.
REQ-021 tx_data SHALL hold its last value in IDLE.
REQ-022 A rejected command in TX_HOLD SHALL go to IDLE and pulse cmd_err.
REQ-023 When WR_DATA targets the current rd_addr, a following RD_DATA SHALL return the newly written value (no stale read).

Reset
REQ-024 When rst=1 at an edge, SHALL set: tx_data=0, tx_valid=0, cmd_err=0, FSM=IDLE, wr_addr=0, rd_addr=0, wr_addr_ok=0, rd_addr_ok=0, rx_valid_q=1.
REQ-025 SHALL treat rx_valid already high when reset deasserts as not a new command.
REQ-026 Reset SHALL NOT clear memory contents.
REQ-027 Reset during TX_HOLD SHALL drop tx_valid at that edge.

Structure
REQ-028 Package spi_ram_pkg SHALL hold the opcode enum (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA) and the state enum (IDLE, TX_HOLD).
REQ-029 The memory array SHALL be a sub-module, spi_dpram: one write port, one registered read port, no reset.
REQ-030 The edge detector, address registers and FSM SHALL live in spi_ram_ctrl.

Verification
REQ-031 Reset, then issue WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> tx_data=0xA5 and tx_valid=1 one cycle after the RD_DATA edge.
REQ-032 Hold rx_valid high 12 cycles with WR_DATA 0x3C after WR_ADDR 0x20 -> only mem[0x20]=0x3C is written; mem[0x21] is unchanged.
REQ-033 Write 0x11 and 0x22 to addresses 0xFF and 0x00 using a single WR_ADDR 0xFF, then RD_ADDR 0xFF and two RD_DATA -> returns 0x11 then 0x22 (wrap).
REQ-034 Issue RD_DATA after reset with no RD_ADDR -> one cmd_err pulse, tx_valid stays 0.
REQ-035 Assert rst while tx_valid=1 and rx_valid held high -> tx_valid=0 next edge and no command executes after release; memory data is still readable.
REQ-036 In TX_HOLD, issue WR_ADDR 0x05 -> tx_valid drops 1 cycle later and tx_data is unchanged.
